// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared screen and task codes for the game flow controller and the drawing
// stage, so both sides agree on what each numeric code means.
//   - ST_*   : 4-bit screen codes driven on game_flow_ctrl.state
//   - TODO_* : 2-bit task codes driven on game_flow_ctrl.todo
//   - isStage(): true for the three playable stage screens
// ---------------------------------------------------------------------------
package game_pkg;

    localparam logic [3:0] ST_TITLE    = 4'd0;
    localparam logic [3:0] ST_STAFF    = 4'd1;
    localparam logic [3:0] ST_STAGE1   = 4'd2;
    localparam logic [3:0] ST_SUCCESS1 = 4'd3;
    localparam logic [3:0] ST_STAGE2   = 4'd4;
    localparam logic [3:0] ST_SUCCESS2 = 4'd5;
    localparam logic [3:0] ST_STAGE3   = 4'd6;
    localparam logic [3:0] ST_SUCCESS3 = 4'd7;
    localparam logic [3:0] ST_FAIL     = 4'd8;
    localparam logic [3:0] ST_HELP     = 4'd9;

    localparam logic [1:0] TODO_NONE       = 2'd0;
    localparam logic [1:0] TODO_FIND_KEY   = 2'd1;
    localparam logic [1:0] TODO_FIND_LIGHT = 2'd2;
    localparam logic [1:0] TODO_FIND_DOOR  = 2'd3;

    // Gameplay events are only meaningful on the three stage screens.
    function automatic logic isStage(input logic [3:0] s);
        return (s == ST_STAGE1) || (s == ST_STAGE2) || (s == ST_STAGE3);
    endfunction

endpackage

// File: rtl/ui_button_hit.sv
// ---------------------------------------------------------------------------
// ui_button_hit
// Combinational test of one on-screen button: a hit is a click while the
// cursor lies in the half-open rectangle [x0,x1) x [y0,y1) of the 320x240
// UI space.
//   click_i  : one-cycle mouse press pulse
//   x_i, y_i : cursor position (9 bits each)
//   hit_o    : button pressed this cycle
// ---------------------------------------------------------------------------
module ui_button_hit #(
    parameter logic [8:0] x0 = 9'd120,
    parameter logic [8:0] x1 = 9'd200,
    parameter logic [8:0] y0 = 9'd0,
    parameter logic [8:0] y1 = 9'd0
) (
    input  logic       click_i,
    input  logic [8:0] x_i,
    input  logic [8:0] y_i,
    output logic       hit_o
);

    assign hit_o = click_i && (x_i >= x0) && (x_i < x1) && (y_i >= y0) && (y_i < y1);

endmodule

// File: rtl/game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl
// Screen flow, per-stage task progress, key count, lives and stage unlock
// mask for the game. All outputs are registered.
//   clk, rst_n                  : clock, synchronous active-low reset
//   click, mouse_x, mouse_y     : mouse press pulse and cursor (UI space)
//   evt_key/light/door/hit      : one-cycle gameplay event pulses
//   state, todo                 : screen code and current task code
//   key_find, life, play_valid  : keys held, lives left, stage unlock mask
// Build option: define STAGE_UNLOCK_ALL_EN to start with every stage
// unlocked (play_valid resets to 4'b1110).
// ---------------------------------------------------------------------------
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter logic [25:0] HIT_GUARD_CYCLES = 26'd50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       click,
    input  logic [8:0] mouse_x,
    input  logic [8:0] mouse_y,
    input  logic       evt_key,
    input  logic       evt_light,
    input  logic       evt_door,
    input  logic       evt_hit,
    output logic [3:0] state,
    output logic [1:0] todo,
    output logic [1:0] key_find,
    output logic [1:0] life,
    output logic [3:0] play_valid
);

`ifdef STAGE_UNLOCK_ALL_EN
    localparam logic [3:0] PLAY_VALID_RST = 4'b1110;
`else
    localparam logic [3:0] PLAY_VALID_RST = 4'b0010;
`endif

    logic [3:0]  state_q, state_d;
    logic [1:0]  todo_q, todo_d;
    logic [1:0]  keyFind_q, keyFind_d;
    logic [1:0]  life_q, life_d;
    logic [25:0] guard_q, guard_d;
    logic [3:0]  playValid_q, playValid_d;

    // Several screens share a rectangle, so one instance serves each
    // distinct rectangle and the screen decides what it means.
    logic hitY120, hitY150, hitY180, hitY210, hitY140, hitY200;

    ui_button_hit #(.y0(9'd120), .y1(9'd140)) uBtnY120 (.click_i(click), .x_i(mouse_x), .y_i(mouse_y), .hit_o(hitY120));
    ui_button_hit #(.y0(9'd150), .y1(9'd170)) uBtnY150 (.click_i(click), .x_i(mouse_x), .y_i(mouse_y), .hit_o(hitY150));
    ui_button_hit #(.y0(9'd180), .y1(9'd200)) uBtnY180 (.click_i(click), .x_i(mouse_x), .y_i(mouse_y), .hit_o(hitY180));
    ui_button_hit #(.y0(9'd210), .y1(9'd230)) uBtnY210 (.click_i(click), .x_i(mouse_x), .y_i(mouse_y), .hit_o(hitY210));
    ui_button_hit #(.y0(9'd140), .y1(9'd160)) uBtnY140 (.click_i(click), .x_i(mouse_x), .y_i(mouse_y), .hit_o(hitY140));
    ui_button_hit #(.y0(9'd200), .y1(9'd220)) uBtnY200 (.click_i(click), .x_i(mouse_x), .y_i(mouse_y), .hit_o(hitY200));

    // Next-state logic. A hit that empties the last life wins over every
    // other event; otherwise only the task that is currently asked for can
    // advance, which gives door > key > light without extra arbitration.
    // Stage / title / success entry side effects are applied afterwards
    // by comparing the old and new screen.
    always_comb begin
        state_d     = state_q;
        todo_d      = todo_q;
        keyFind_d   = keyFind_q;
        life_d      = life_q;
        guard_d     = (guard_q != 26'd0) ? guard_q - 26'd1 : 26'd0;
        playValid_d = playValid_q;

        case (state_q)
            ST_TITLE: begin
                if (hitY120)                         state_d = ST_STAGE1;
                else if (hitY150 && playValid_q[2])  state_d = ST_STAGE2;
                else if (hitY180 && playValid_q[3])  state_d = ST_STAGE3;
                else if (hitY210)                    state_d = ST_HELP;
            end
            ST_SUCCESS1: begin
                if (hitY140)      state_d = ST_STAGE2;
                else if (hitY180) state_d = ST_TITLE;
            end
            ST_SUCCESS2: begin
                if (hitY140)      state_d = ST_STAGE3;
                else if (hitY180) state_d = ST_TITLE;
            end
            ST_SUCCESS3: begin
                if (hitY150) state_d = ST_STAFF;
            end
            ST_FAIL: begin
                if (hitY140)      state_d = ST_STAGE3;
                else if (hitY180) state_d = ST_TITLE;
            end
            ST_STAFF: begin
                if (hitY180) state_d = ST_TITLE;
            end
            ST_HELP: begin
                if (hitY200) state_d = ST_TITLE;
            end
            ST_STAGE1, ST_STAGE2, ST_STAGE3: begin
                if (evt_hit && state_q == ST_STAGE3 && guard_q == 26'd0) begin
                    life_d  = life_q - 2'd1;
                    guard_d = HIT_GUARD_CYCLES;
                end
                if (evt_hit && state_q == ST_STAGE3 && guard_q == 26'd0 && life_q == 2'd1) begin
                    state_d = ST_FAIL;
                    todo_d  = TODO_NONE;
                end else if (evt_door && todo_q == TODO_FIND_DOOR) begin
                    state_d = state_q + 4'd1;
                    todo_d  = TODO_NONE;
                end else if (evt_key && todo_q == TODO_FIND_KEY) begin
                    if (keyFind_q != 2'd3) keyFind_d = keyFind_q + 2'd1;
                    if (keyFind_q == 2'd2) todo_d = TODO_FIND_DOOR;
                end else if (evt_light && todo_q == TODO_FIND_LIGHT) begin
                    todo_d = TODO_FIND_KEY;
                end
            end
            default: state_d = ST_TITLE;
        endcase

        if (isStage(state_d) && !isStage(state_q)) begin
            keyFind_d = 2'd0;
            life_d    = 2'd3;
            guard_d   = 26'd0;
            todo_d    = (state_d == ST_STAGE2) ? TODO_FIND_LIGHT : TODO_FIND_KEY;
        end
        if (state_d == ST_TITLE && state_q != ST_TITLE) todo_d = TODO_NONE;
        if (state_d == ST_SUCCESS1) playValid_d[2] = 1'b1;
        if (state_d == ST_SUCCESS2) playValid_d[3] = 1'b1;
        playValid_d[1:0] = 2'b10;
    end

    // State registers; reset wins over every input in the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_TITLE;
            todo_q      <= TODO_NONE;
            keyFind_q   <= 2'd0;
            life_q      <= 2'd3;
            guard_q     <= 26'd0;
            playValid_q <= PLAY_VALID_RST;
        end else begin
            state_q     <= state_d;
            todo_q      <= todo_d;
            keyFind_q   <= keyFind_d;
            life_q      <= life_d;
            guard_q     <= guard_d;
            playValid_q <= playValid_d;
        end
    end

    assign state      = state_q;
    assign todo       = todo_q;
    assign key_find   = keyFind_q;
    assign life       = life_q;
    assign play_valid = playValid_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_flow_ctrl
// Directed bench for game_flow_ctrl with HIT_GUARD_CYCLES = 4. Each scenario
// task drives its own stimulus and compares outputs against hand-computed
// values one edge later. Honors STAGE_UNLOCK_ALL_EN for the unlock cases.
// ---------------------------------------------------------------------------
module tb_game_flow_ctrl;

`ifdef STAGE_UNLOCK_ALL_EN
    localparam logic [3:0] PV_RST = 4'b1110;
    localparam logic [3:0] PV_S1  = 4'b1110;
`else
    localparam logic [3:0] PV_RST = 4'b0010;
    localparam logic [3:0] PV_S1  = 4'b0110;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       click;
    logic [8:0] mouse_x, mouse_y;
    logic       evt_key, evt_light, evt_door, evt_hit;
    logic [3:0] state;
    logic [1:0] todo, key_find, life;
    logic [3:0] play_valid;

    int assertCount = 0;
    int failCount   = 0;

    game_flow_ctrl #(.HIT_GUARD_CYCLES(26'd4)) dut (
        .clk(clk), .rst_n(rst_n), .click(click), .mouse_x(mouse_x), .mouse_y(mouse_y),
        .evt_key(evt_key), .evt_light(evt_light), .evt_door(evt_door), .evt_hit(evt_hit),
        .state(state), .todo(todo), .key_find(key_find), .life(life), .play_valid(play_valid)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle click at (x,y).
    task automatic clickAt(input int x, input int y);
        click = 1'b1; mouse_x = 9'(x); mouse_y = 9'(y);
        tick();
        click = 1'b0;
    endtask

    // One-cycle event pulse: bits {hit, door, key, light}.
    task automatic pulseEvents(input logic [3:0] ev);
        {evt_hit, evt_door, evt_key, evt_light} = ev;
        tick();
        {evt_hit, evt_door, evt_key, evt_light} = 4'b0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        click = 1'b1; mouse_x = 9'd130; mouse_y = 9'd125; evt_key = 1'b1;
        tick();
        click = 1'b0; evt_key = 1'b0;
        assertCount++; if (state !== 4'd0) begin failCount++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        assertCount++; if (todo !== 2'd0) begin failCount++; $display("[TB] FAIL reset_todo: got %0d expected 0", todo); end
        assertCount++; if (key_find !== 2'd0) begin failCount++; $display("[TB] FAIL reset_key: got %0d expected 0", key_find); end
        assertCount++; if (life !== 2'd3) begin failCount++; $display("[TB] FAIL reset_life: got %0d expected 3", life); end
        assertCount++; if (play_valid !== PV_RST) begin failCount++; $display("[TB] FAIL reset_pv: got %b expected %b", play_valid, PV_RST); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stage1();
        clickAt(200, 125);
        assertCount++; if (state !== 4'd0) begin failCount++; $display("[TB] FAIL edge_x200: got %0d expected 0", state); end
        clickAt(130, 140);
        assertCount++; if (state !== 4'd0) begin failCount++; $display("[TB] FAIL edge_y140: got %0d expected 0", state); end
        clickAt(130, 125);
        assertCount++; if (state !== 4'd2) begin failCount++; $display("[TB] FAIL s1_state: got %0d expected 2", state); end
        assertCount++; if (todo !== 2'd1) begin failCount++; $display("[TB] FAIL s1_todo: got %0d expected 1", todo); end
        assertCount++; if (key_find !== 2'd0) begin failCount++; $display("[TB] FAIL s1_key: got %0d expected 0", key_find); end
        assertCount++; if (life !== 2'd3) begin failCount++; $display("[TB] FAIL s1_life: got %0d expected 3", life); end
        for (int k = 1; k <= 3; k++) begin
            pulseEvents(4'b0010);
            assertCount++; if (key_find !== 2'(k)) begin failCount++; $display("[TB] FAIL s1_key%0d: got %0d expected %0d", k, key_find, k); end
        end
        assertCount++; if (todo !== 2'd3) begin failCount++; $display("[TB] FAIL s1_todo_door: got %0d expected 3", todo); end
        pulseEvents(4'b0010);
        assertCount++; if (key_find !== 2'd3) begin failCount++; $display("[TB] FAIL s1_key_sat: got %0d expected 3", key_find); end
        pulseEvents(4'b1000);
        assertCount++; if (life !== 2'd3) begin failCount++; $display("[TB] FAIL s1_hit_ignored: got %0d expected 3", life); end
        pulseEvents(4'b0100);
        assertCount++; if (state !== 4'd3) begin failCount++; $display("[TB] FAIL s1_success: got %0d expected 3", state); end
        assertCount++; if (todo !== 2'd0) begin failCount++; $display("[TB] FAIL s1_todo_none: got %0d expected 0", todo); end
        assertCount++; if (play_valid !== PV_S1) begin failCount++; $display("[TB] FAIL s1_pv: got %b expected %b", play_valid, PV_S1); end
        clickAt(130, 185);
        assertCount++; if (state !== 4'd0) begin failCount++; $display("[TB] FAIL s1_to_title: got %0d expected 0", state); end
    endtask

    task automatic test_locked_stage3();
        clickAt(130, 185);
`ifdef STAGE_UNLOCK_ALL_EN
        assertCount++; if (state !== 4'd6) begin failCount++; $display("[TB] FAIL unlock_all_s3: got %0d expected 6", state); end
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
`else
        assertCount++; if (state !== 4'd0) begin failCount++; $display("[TB] FAIL locked_s3: got %0d expected 0", state); end
`endif
    endtask

    task automatic test_stage2();
        clickAt(130, 155);
        assertCount++; if (state !== 4'd4) begin failCount++; $display("[TB] FAIL s2_state: got %0d expected 4", state); end
        assertCount++; if (todo !== 2'd2) begin failCount++; $display("[TB] FAIL s2_todo: got %0d expected 2", todo); end
        pulseEvents(4'b0010);
        assertCount++; if (key_find !== 2'd0) begin failCount++; $display("[TB] FAIL s2_early_key: got %0d expected 0", key_find); end
        pulseEvents(4'b0001);
        assertCount++; if (todo !== 2'd1) begin failCount++; $display("[TB] FAIL s2_light: got %0d expected 1", todo); end
        for (int k = 0; k < 3; k++) pulseEvents(4'b0010);
        pulseEvents(4'b0100);
        assertCount++; if (state !== 4'd5) begin failCount++; $display("[TB] FAIL s2_success: got %0d expected 5", state); end
        assertCount++; if (play_valid !== 4'b1110) begin failCount++; $display("[TB] FAIL s2_pv: got %b expected 1110", play_valid); end
        clickAt(130, 145);
        assertCount++; if (state !== 4'd6) begin failCount++; $display("[TB] FAIL s3_state: got %0d expected 6", state); end
        assertCount++; if (todo !== 2'd1) begin failCount++; $display("[TB] FAIL s3_todo: got %0d expected 1", todo); end
    endtask

    task automatic test_hit_guard();
        logic [1:0] expLife;
        expLife = 2'd3;
        for (int c = 0; c <= 10; c++) begin
            if (c == 0 || c == 2 || c == 5 || c == 10) begin
                if (c != 2) expLife = expLife - 2'd1;
                pulseEvents(4'b1000);
                assertCount++; if (life !== expLife) begin failCount++; $display("[TB] FAIL hit_c%0d: got %0d expected %0d", c, life, expLife); end
            end else begin
                tick();
            end
        end
        assertCount++; if (state !== 4'd8) begin failCount++; $display("[TB] FAIL hit_fail_state: got %0d expected 8", state); end
        assertCount++; if (todo !== 2'd0) begin failCount++; $display("[TB] FAIL hit_fail_todo: got %0d expected 0", todo); end
        clickAt(130, 145);
        assertCount++; if (state !== 4'd6) begin failCount++; $display("[TB] FAIL retry_state: got %0d expected 6", state); end
        assertCount++; if (life !== 2'd3) begin failCount++; $display("[TB] FAIL retry_life: got %0d expected 3", life); end
    endtask

    task automatic test_simultaneous();
        pulseEvents(4'b1000);
        for (int k = 0; k < 3; k++) pulseEvents(4'b0010);
        tick();
        pulseEvents(4'b1000);
        for (int k = 0; k < 4; k++) tick();
        assertCount++; if (life !== 2'd1) begin failCount++; $display("[TB] FAIL sim_pre_life: got %0d expected 1", life); end
        assertCount++; if (todo !== 2'd3) begin failCount++; $display("[TB] FAIL sim_pre_todo: got %0d expected 3", todo); end
        pulseEvents(4'b1100);
        assertCount++; if (state !== 4'd8) begin failCount++; $display("[TB] FAIL sim_fail_state: got %0d expected 8", state); end
        assertCount++; if (life !== 2'd0) begin failCount++; $display("[TB] FAIL sim_fail_life: got %0d expected 0", life); end
        clickAt(130, 145);
        for (int k = 0; k < 3; k++) pulseEvents(4'b0010);
        pulseEvents(4'b1100);
        assertCount++; if (state !== 4'd7) begin failCount++; $display("[TB] FAIL sim_success_state: got %0d expected 7", state); end
        assertCount++; if (life !== 2'd2) begin failCount++; $display("[TB] FAIL sim_success_life: got %0d expected 2", life); end
        clickAt(130, 155);
        assertCount++; if (state !== 4'd1) begin failCount++; $display("[TB] FAIL staff_state: got %0d expected 1", state); end
        pulseEvents(4'b1111);
        assertCount++; if (key_find !== 2'd3 || life !== 2'd2) begin failCount++; $display("[TB] FAIL staff_events: got key %0d life %0d expected key 3 life 2", key_find, life); end
        clickAt(130, 185);
        assertCount++; if (state !== 4'd0) begin failCount++; $display("[TB] FAIL staff_to_title: got %0d expected 0", state); end
    endtask

    task automatic test_help();
        clickAt(130, 215);
        assertCount++; if (state !== 4'd9) begin failCount++; $display("[TB] FAIL help_state: got %0d expected 9", state); end
        clickAt(130, 225);
        assertCount++; if (state !== 4'd9) begin failCount++; $display("[TB] FAIL help_outside: got %0d expected 9", state); end
        clickAt(130, 219);
        assertCount++; if (state !== 4'd0) begin failCount++; $display("[TB] FAIL help_back: got %0d expected 0", state); end
    endtask

    task automatic test_reset_mid_stage();
        clickAt(130, 185);
        assertCount++; if (state !== 4'd6) begin failCount++; $display("[TB] FAIL mid_enter: got %0d expected 6", state); end
        pulseEvents(4'b1010);
        assertCount++; if (life !== 2'd2 || key_find !== 2'd1) begin failCount++; $display("[TB] FAIL mid_pre: got life %0d key %0d expected life 2 key 1", life, key_find); end
        rst_n = 1'b0;
        tick();
        {evt_hit, evt_key} = 2'b11;
        tick();
        {evt_hit, evt_key} = 2'b00;
        assertCount++; if (state !== 4'd0) begin failCount++; $display("[TB] FAIL mid_rst_state: got %0d expected 0", state); end
        assertCount++; if (life !== 2'd3 || key_find !== 2'd0) begin failCount++; $display("[TB] FAIL mid_rst_vals: got life %0d key %0d expected life 3 key 0", life, key_find); end
        assertCount++; if (play_valid !== PV_RST) begin failCount++; $display("[TB] FAIL mid_rst_pv: got %b expected %b", play_valid, PV_RST); end
        rst_n = 1'b1;
        tick();
    endtask

    // Scenario sequence; each task starts from where the previous left off.
    initial begin
        rst_n = 1'b0; click = 1'b0; mouse_x = 9'd0; mouse_y = 9'd0;
        evt_key = 1'b0; evt_light = 1'b0; evt_door = 1'b0; evt_hit = 1'b0;
        test_reset();
        test_stage1();
        test_locked_stage3();
        test_stage2();
        test_hit_guard();
        test_simultaneous();
        test_help();
        test_reset_mid_stage();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
